// File: rtl/tx_pingpong_ctrl.sv
// Ping-pong ownership scheduler for the two TX buffer halves: the writer fills one half while the reader drains the other.
// State | meaning: IDLE = waiting for the half at rd_half to become full; BUSY = reader owns rd_half, timeout running.
module tx_pingpong_ctrl #(
    parameter int TIMEOUT_CYC = 4096,
    parameter int TO_NBIT     = 13
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_eop,
    output logic       wr_half,
    output logic       wr_ready,
    output logic       wr_ovf,
    output logic       rd_start,
    output logic       rd_half,
    input  logic       rd_done,
    output logic       rd_timeout,
    output logic [1:0] half_full,
    output logic       busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [TO_NBIT-1:0] CNT_LAST = TO_NBIT'(TIMEOUT_CYC - 1);

    state_t             state, state_nxt;
    logic [1:0]         full, full_nxt;
    logic               wr_half_nxt, rd_half_nxt;
    logic [TO_NBIT-1:0] cnt, cnt_nxt;
    logic               wr_ovf_nxt, rd_start_nxt, rd_timeout_nxt;
    logic               wr_accept, rd_release;

    assign wr_ready  = ~full[wr_half];
    assign half_full = full;
    assign busy      = (state == BUSY);

    always_comb begin
        state_nxt      = state;
        full_nxt       = full;
        wr_half_nxt    = wr_half;
        rd_half_nxt    = rd_half;
        cnt_nxt        = cnt;
        rd_start_nxt   = 1'b0;
        rd_timeout_nxt = 1'b0;
        rd_release     = 1'b0;
        wr_accept      = wr_eop & wr_ready;
        wr_ovf_nxt     = wr_eop & ~wr_ready;

        case (state)
            IDLE: begin
                if (full[rd_half]) begin
                    state_nxt    = BUSY;
                    rd_start_nxt = 1'b1;
                    cnt_nxt      = '0;
                end
            end
            BUSY: begin
                // rd_done wins over a timeout landing on the same edge
                if (rd_done) begin
                    rd_release = 1'b1;
                    state_nxt  = IDLE;
                end else if (cnt == CNT_LAST) begin
                    rd_release     = 1'b1;
                    rd_timeout_nxt = 1'b1;
                    state_nxt      = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A write only targets an empty half and a release only a full one, so both can apply together
        if (rd_release) begin
            full_nxt[rd_half] = 1'b0;
            rd_half_nxt       = ~rd_half;
        end
        if (wr_accept) begin
            full_nxt[wr_half] = 1'b1;
            wr_half_nxt       = ~wr_half;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            full       <= 2'b00;
            wr_half    <= 1'b0;
            rd_half    <= 1'b0;
            cnt        <= '0;
            wr_ovf     <= 1'b0;
            rd_start   <= 1'b0;
            rd_timeout <= 1'b0;
        end else begin
            state      <= state_nxt;
            full       <= full_nxt;
            wr_half    <= wr_half_nxt;
            rd_half    <= rd_half_nxt;
            cnt        <= cnt_nxt;
            wr_ovf     <= wr_ovf_nxt;
            rd_start   <= rd_start_nxt;
            rd_timeout <= rd_timeout_nxt;
        end
    end

endmodule

// File: tb/tb_tx_pingpong_ctrl.sv
// Randomized scoreboard bench for tx_pingpong_ctrl against a fill-order queue model of the two buffer halves.
module tb_tx_pingpong_ctrl;
    localparam int TO = 16;
    localparam int NB = 5;

    logic       clk = 1'b0;
    logic       rst_n, wr_eop, rd_done;
    logic       wr_half, wr_ready, wr_ovf, rd_start, rd_half, rd_timeout, busy;
    logic [1:0] half_full;

    tx_pingpong_ctrl #(.TIMEOUT_CYC(TO), .TO_NBIT(NB)) dut (
        .clk(clk), .rst_n(rst_n), .wr_eop(wr_eop), .wr_half(wr_half), .wr_ready(wr_ready),
        .wr_ovf(wr_ovf), .rd_start(rd_start), .rd_half(rd_half), .rd_done(rd_done),
        .rd_timeout(rd_timeout), .half_full(half_full), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    // Model: halves in the order they were filled; reads follow that order and free the oldest one.
    int edge_n = 0;
    int fill_q[$];
    int n_wr = 0, n_rel = 0;
    bit m_reading = 0;
    int start_edge = 0;
    bit armed = 0;
    int q_start[$], q_start_half[$], q_ovf[$], q_to[$];
    bit acc, ovf, rel, tmo, st;

    always @(posedge clk) begin
        edge_n++;
        if (!rst_n) begin
            fill_q.delete();
            n_wr = 0; n_rel = 0; m_reading = 0;
            armed = 1;
        end else if (armed) begin
            acc = wr_eop && (fill_q.size() < 2);
            ovf = wr_eop && !acc;
            rel = 0; tmo = 0;
            if (m_reading) begin
                if (rd_done) rel = 1;
                else if (edge_n - start_edge == TO) begin rel = 1; tmo = 1; end
            end
            st = !m_reading && (fill_q.size() > 0);
            if (st) begin
                m_reading  = 1;
                start_edge = edge_n;
                q_start.push_back(edge_n);
                q_start_half.push_back(fill_q[0]);
            end
            if (rel) begin
                void'(fill_q.pop_front());
                n_rel++;
                m_reading = 0;
            end
            if (acc) begin
                fill_q.push_back(n_wr % 2);
                n_wr++;
            end
            if (ovf) q_ovf.push_back(edge_n);
            if (tmo) q_to.push_back(edge_n);
        end
    end

    function automatic int exp_full();
        int f = 0;
        foreach (fill_q[i]) f |= (1 << fill_q[i]);
        return f;
    endfunction

    bit e_st, e_ovf, e_to;

    always @(negedge clk) begin
        if (armed) begin
            chk("half_full", int'(half_full), exp_full());
            chk("wr_ready", int'(wr_ready), int'(fill_q.size() < 2));
            chk("wr_half", int'(wr_half), n_wr % 2);
            chk("rd_half", int'(rd_half), n_rel % 2);
            chk("busy", int'(busy), int'(m_reading));

            while (q_start.size() > 0 && q_start[0] < edge_n) begin
                chk("rd_start_late", q_start[0], edge_n);
                void'(q_start.pop_front()); void'(q_start_half.pop_front());
            end
            while (q_ovf.size() > 0 && q_ovf[0] < edge_n) begin
                chk("wr_ovf_late", q_ovf[0], edge_n); void'(q_ovf.pop_front());
            end
            while (q_to.size() > 0 && q_to[0] < edge_n) begin
                chk("rd_timeout_late", q_to[0], edge_n); void'(q_to.pop_front());
            end

            e_st  = (q_start.size() > 0) && (q_start[0] == edge_n);
            e_ovf = (q_ovf.size() > 0) && (q_ovf[0] == edge_n);
            e_to  = (q_to.size() > 0) && (q_to[0] == edge_n);
            chk("rd_start", int'(rd_start), int'(e_st));
            chk("wr_ovf", int'(wr_ovf), int'(e_ovf));
            chk("rd_timeout", int'(rd_timeout), int'(e_to));
            if (e_st) begin
                chk("rd_start_half", int'(rd_half), q_start_half[0]);
                void'(q_start.pop_front()); void'(q_start_half.pop_front());
            end
            if (e_ovf) void'(q_ovf.pop_front());
            if (e_to) void'(q_to.pop_front());
        end
    end

    int p_wr, p_done;

    initial begin
        rst_n = 1'b0; wr_eop = 1'b0; rd_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            // Alternate traffic phases: fast reader, slow reader (timeouts), writer flooding
            case ((i / 400) % 3)
                0: begin p_wr = 30; p_done = 25; end
                1: begin p_wr = 20; p_done = 4;  end
                default: begin p_wr = 70; p_done = 12; end
            endcase
            wr_eop  = ($urandom_range(0, 99) < p_wr);
            rd_done = ($urandom_range(0, 99) < p_done);
            rst_n   = ($urandom_range(0, 599) != 0);
        end
        @(negedge clk);
        wr_eop = 1'b0; rd_done = 1'b0; rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
